// File: rtl/loa_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : loa_share_arbiter
//  Purpose  : Round-robin arbiter sharing one 16-bit lower-part-OR approximate
//             adder (OR on the low K bits, exact ripple on the upper bits)
//             between N valid/ready requesters. The result is registered and
//             tagged with the ID of the requester that was served.
//  Revision : 1.0  initial release
// ============================================================================
module loa_share_arbiter #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int K = 8,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_sum,
  output logic           res_carry,
  output logic [IDW-1:0] res_id,
  output logic [15:0]    op_count
);

  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

  logic [IDW-1:0] ptr;
  logic [W-1:0]   op_a [N];
  logic [W-1:0]   op_b [N];

  logic           can_issue;
  logic           grant_found;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  int             idx;
  logic           transfer;

  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic           loa_cin;
  logic [W-K:0]   upper;
  logic [W-1:0]   loa_sum;
  logic           loa_carry;

  // Split the packed operand buses into per-requester words.
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign op_a[i] = req_a[i*W +: W];
    assign op_b[i] = req_b[i*W +: W];
  end

  // A new operation may enter only if the result slot is empty or being drained.
  assign can_issue = !res_valid || res_ready;

  // Round-robin search: first valid requester at or after ptr, wrapping at N.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    cand        = '0;
    for (int j = 0; j < N; j++) begin
      idx = int'(ptr) + j;
      if (idx >= N) begin
        idx = idx - N;
      end
      cand = IDW'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Grant is one-hot and suppressed while in reset or while the result stalls.
  assign transfer = rst_n && can_issue && grant_found;

  // One-hot ready towards the granted requester only.
  always_comb begin
    req_ready = '0;
    if (transfer) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Shared LOA: OR on the low part, exact add on the upper part with a carry
  // injected from the AND of the two low-part MSBs.
  assign sel_a     = op_a[grant_id];
  assign sel_b     = op_b[grant_id];
  assign loa_cin   = sel_a[K-1] & sel_b[K-1];
  assign upper     = {1'b0, sel_a[W-1:K]} + {1'b0, sel_b[W-1:K]} + {{(W-K){1'b0}}, loa_cin};
  assign loa_sum   = {upper[W-K-1:0], sel_a[K-1:0] | sel_b[K-1:0]};
  assign loa_carry = upper[W-K];

  // Pointer, result register and handshake counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_carry <= 1'b0;
      res_id    <= '0;
      op_count  <= '0;
    end else begin
      if (res_valid && res_ready) begin
        op_count <= op_count + 16'd1;
      end
      if (transfer) begin
        ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        res_valid <= 1'b1;
        res_sum   <= loa_sum;
        res_carry <= loa_carry;
        res_id    <= grant_id;
      end else if (res_valid && res_ready) begin
        // Drained with nothing new: data fields keep their last values.
        res_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_loa_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_loa_share_arbiter
//  Purpose  : Self-checking bench for loa_share_arbiter. Directed scenarios
//             followed by randomized traffic, compared against an arithmetic
//             reference model of the arbiter, adder and result slot.
//  Revision : 1.0  initial release
// ============================================================================
module tb_loa_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic           res_carry;
  logic [IDW-1:0] res_id;
  logic [15:0]    op_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_ptr;
  int m_valid;
  int m_sum;
  int m_carry;
  int m_id;
  int m_cnt;

  loa_share_arbiter #(.N(N), .W(W), .K(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .op_count  (op_count)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Approximate sum as plain arithmetic: result = {carry, sum}.
  function automatic int loa_ref(input int a, input int b);
    int lo, cin, hi;
    lo  = (a % 256) | (b % 256);
    cin = ((a / 128) % 2) & ((b / 128) % 2);
    hi  = (a / 256) + (b / 256) + cin;
    return hi * 256 + lo;
  endfunction

  function automatic int get_a(input int i);
    return int'(req_a[i*W +: W]);
  endfunction

  function automatic int get_b(input int i);
    return int'(req_b[i*W +: W]);
  endfunction

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      set_req(i, W'($urandom), W'($urandom));
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0;
  endtask

  // One clock: called at a negedge with inputs already applied.
  task automatic cycle();
    int g, r;
    logic [N-1:0] exp_ready;
    g = -1;
    if (rst_n && (m_valid == 0 || res_ready)) begin
      for (int j = 0; j < N; j++) begin
        if (g < 0 && req_valid[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      end
    end
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_valid != 0 && res_ready) m_cnt = (m_cnt + 1) % 65536;
      if (g >= 0) begin
        r       = loa_ref(get_a(g), get_b(g));
        m_sum   = r % 65536;
        m_carry = r / 65536;
        m_id    = g;
        m_valid = 1;
        m_ptr   = (g + 1) % N;
      end else if (m_valid != 0 && res_ready) begin
        m_valid = 0;
      end
    end
    #1;
    chk("res_valid", 32'(res_valid), 32'(m_valid));
    chk("res_sum",   32'(res_sum),   32'(m_sum));
    chk("res_carry", 32'(res_carry), 32'(m_carry));
    chk("res_id",    32'(res_id),    32'(m_id));
    chk("op_count",  32'(op_count),  32'(m_cnt));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_ids [6];
    exp_ids = '{0, 1, 2, 3, 0, 1};
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b1; req_a = '0; req_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset();
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_count", 32'(op_count), 0);

    // Single requester 0: low-part OR loses the exact carry.
    req_valid = 4'b0001; set_req(0, 16'h00FF, 16'h0001);
    cycle();
    chk("single_sum", 32'(res_sum), 32'h00FF);
    chk("single_carry", 32'(res_carry), 0);
    chk("single_id", 32'(res_id), 0);

    // Carry injection from the low-part MSBs.
    set_req(0, 16'h0080, 16'h0080);
    cycle();
    chk("cin_sum", 32'(res_sum), 32'h0180);
    chk("cin_carry", 32'(res_carry), 0);
    set_req(0, 16'hFF80, 16'h0080);
    cycle();
    chk("cout_sum", 32'(res_sum), 32'h0080);
    chk("cout_carry", 32'(res_carry), 1);

    // Fairness: all valid from reset.
    do_reset();
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      rand_ops();
      cycle();
      chk("rr_id", 32'(res_id), 32'(exp_ids[n]));
    end
    req_valid = '0;
    cycle();
    chk("rr_count", 32'(op_count), 6);

    // Backpressure: result held, no grants, then resume from saved pointer.
    req_valid = 4'b1111; res_ready = 1'b0;
    cycle();
    chk("bp_first_id", 32'(res_id), 2);
    for (int n = 0; n < 5; n++) begin
      rand_ops();
      cycle();
      chk("bp_held_id", 32'(res_id), 2);
    end
    res_ready = 1'b1;
    cycle();
    chk("bp_resume_id", 32'(res_id), 3);

    // Sparse: ptr=1 with requests 0 and 2 -> 2 then 0.
    do_reset();
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0101;
    cycle();
    chk("sparse_id0", 32'(res_id), 2);
    cycle();
    chk("sparse_id1", 32'(res_id), 0);

    // Reset while a result is stalled.
    do_reset();
    req_valid = 4'b1111; res_ready = 1'b1;
    repeat (4) cycle();
    res_ready = 1'b0;
    cycle();
    chk("stall_count", 32'(op_count), 3);
    chk("stall_valid", 32'(res_valid), 1);
    do_reset();
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_sum", 32'(res_sum), 0);
    chk("mid_rst_count", 32'(op_count), 0);
    req_valid = 4'b1010; res_ready = 1'b1;
    cycle();
    chk("post_rst_id", 32'(res_id), 1);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 39) != 0);
      cycle();
    end

    // op_count wrap after 65536 handshakes.
    do_reset();
    req_valid = 4'b1111; res_ready = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      if (n % 64 == 0) rand_ops();
      cycle();
      if (n == 65535) chk("cnt_ffff", 32'(op_count), 32'hFFFF);
    end
    chk("cnt_wrap", 32'(op_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
